// File: rtl/online_tester_ctrl.sv
// Window sequencer for the online RNG tester: frames entropy bits into
// fixed-size windows, broadcasts them to the tests and grades the results.
module online_tester_ctrl #(
    parameter int NUM_TESTS    = 4,
    parameter int WINDOW_BITS  = 20000,
    parameter int CNT_W        = 15,
    parameter int DONE_TIMEOUT = 256,
    parameter int ERROR_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear_error,
    input  logic                 bit_valid,
    input  logic                 bit_data,
    output logic                 bit_ready,
    output logic                 test_start,
    output logic                 test_sample_valid,
    output logic                 test_sample,
    output logic                 test_stop,
    input  logic [NUM_TESTS-1:0] test_done,
    input  logic [NUM_TESTS-1:0] test_fail,
    output logic                 window_done,
    output logic [NUM_TESTS-1:0] fail_vector,
    output logic                 warning,
    output logic                 error
);

    localparam int TW  = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam int FCW = $clog2(ERROR_THRESH + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WINDOW_BITS - 1);
    localparam logic [TW-1:0]    TMO_MAX  = TW'(DONE_TIMEOUT - 1);
    localparam logic [FCW:0]     THR      = (FCW + 1)'(ERROR_THRESH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_COLLECT,
        S_WAIT,
        S_EVAL
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [TW-1:0]        tmo_q;
    logic [NUM_TESTS-1:0] done_seen_q;
    logic [NUM_TESTS-1:0] fail_seen_q;
    logic [FCW-1:0]       fail_cnt_q;
    logic                 start_q;
    logic                 smp_valid_q;
    logic                 smp_q;
    logic                 stop_q;
    logic                 wdone_q;
    logic [NUM_TESTS-1:0] fvec_q;
    logic                 warn_q;
    logic                 err_q;

    logic                 hs;
    logic [NUM_TESTS-1:0] done_seen_d;
    logic [NUM_TESTS-1:0] fail_seen_d;
    logic [NUM_TESTS-1:0] fvec_d;
    logic [FCW:0]         fail_inc;

    always_comb begin
        bit_ready   = (state_q == S_COLLECT);
        hs          = bit_valid & bit_ready;
        done_seen_d = done_seen_q | test_done;
        fail_seen_d = fail_seen_q | (test_fail & test_done);
        // A test that never reported counts as failed.
        fvec_d      = fail_seen_q | ~done_seen_q;
        fail_inc    = {1'b0, fail_cnt_q} + (FCW + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
            done_seen_q <= '0;
            fail_seen_q <= '0;
            fail_cnt_q  <= '0;
            start_q     <= 1'b0;
            smp_valid_q <= 1'b0;
            smp_q       <= 1'b0;
            stop_q      <= 1'b0;
            wdone_q     <= 1'b0;
            fvec_q      <= '0;
            warn_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            wdone_q     <= 1'b0;
            smp_valid_q <= hs;
            if (hs) begin
                smp_q <= bit_data;
            end
            if (clear_error) begin
                err_q      <= 1'b0;
                fail_cnt_q <= '0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_START;
                        start_q <= 1'b1;
                    end
                end
                S_START: begin
                    bit_cnt_q   <= '0;
                    tmo_q       <= '0;
                    done_seen_q <= '0;
                    fail_seen_q <= '0;
                    state_q     <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (hs) begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            stop_q  <= 1'b1;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    tmo_q       <= tmo_q + TW'(1);
                    done_seen_q <= done_seen_d;
                    fail_seen_q <= fail_seen_d;
                    if ((&done_seen_d) || (tmo_q == TMO_MAX)) begin
                        state_q <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    fvec_q  <= fvec_d;
                    wdone_q <= 1'b1;
                    if (|fvec_d) begin
                        warn_q <= 1'b1;
                        if (fail_inc <= THR) begin
                            fail_cnt_q <= fail_inc[FCW-1:0];
                        end else begin
                            fail_cnt_q <= fail_cnt_q;
                        end
                        if (fail_inc >= THR) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        warn_q     <= 1'b0;
                        fail_cnt_q <= '0;
                    end
                    if (enable) begin
                        state_q <= S_START;
                        start_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign test_start        = start_q;
    assign test_sample_valid = smp_valid_q;
    assign test_sample       = smp_q;
    assign test_stop         = stop_q;
    assign window_done       = wdone_q;
    assign fail_vector       = fvec_q;
    assign warning           = warn_q;
    assign error             = err_q;

endmodule

// File: tb/tb_online_tester_ctrl.sv
// Scoreboard bench for online_tester_ctrl: directed windows, expected
// samples and window verdicts queued at issue and checked by a monitor.
module tb_online_tester_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       clear_error = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_data = 1'b0;
    logic       bit_ready;
    logic       test_start;
    logic       test_sample_valid;
    logic       test_sample;
    logic       test_stop;
    logic [3:0] test_done = 4'b0;
    logic [3:0] test_fail = 4'b0;
    logic       window_done;
    logic [3:0] fail_vector;
    logic       warning;
    logic       error;

    online_tester_ctrl #(
        .NUM_TESTS   (4),
        .WINDOW_BITS (8),
        .CNT_W       (3),
        .DONE_TIMEOUT(16),
        .ERROR_THRESH(2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .clear_error      (clear_error),
        .bit_valid        (bit_valid),
        .bit_data         (bit_data),
        .bit_ready        (bit_ready),
        .test_start       (test_start),
        .test_sample_valid(test_sample_valid),
        .test_sample      (test_sample),
        .test_stop        (test_stop),
        .test_done        (test_done),
        .test_fail        (test_fail),
        .window_done      (window_done),
        .fail_vector      (fail_vector),
        .warning          (warning),
        .error            (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic stop;
    } smp_t;

    typedef struct packed {
        logic [3:0] fv;
        logic       w;
        logic       e;
        int         lat;
    } win_t;

    smp_t sq[$];
    win_t wq[$];
    smp_t s;
    win_t wr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int start_cnt = 0;
    int wd_cnt = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (test_start) start_cnt++;
        if (test_sample_valid) begin
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sample_unexpected: got=%0b want=none", test_sample);
            end else begin
                s = sq.pop_front();
                chk("sample_bit", int'(test_sample), int'(s.b));
                chk("sample_stop", int'(test_stop), int'(s.stop));
            end
        end else if (test_stop) begin
            checks++;
            errors++;
            $display("FAIL stop_without_sample: got=1 want=0");
        end
        if (test_stop) stop_cyc = cyc;
        if (window_done) begin
            wd_cnt++;
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL window_done_unexpected: got=1 want=0");
            end else begin
                wr = wq.pop_front();
                chk("fail_vector", int'(fail_vector), int'(wr.fv));
                chk("warning", int'(warning), int'(wr.w));
                chk("error", int'(error), int'(wr.e));
                if (wr.lat >= 0) chk("eval_latency", cyc - stop_cyc, wr.lat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic last, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!bit_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bit_ready) begin
            checks++;
            errors++;
            $display("FAIL bit_ready_timeout: got=0 want=1");
            return;
        end
        sq.push_back('{b: b, stop: last});
        bit_valid = 1'b1;
        bit_data  = b;
        tick();
        bit_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic wait_wd(input int wd0);
        int n = 0;
        while (wd_cnt == wd0 && n < 100) begin
            tick();
            n++;
        end
        if (wd_cnt == wd0) begin
            checks++;
            errors++;
            $display("FAIL window_done_timeout: got=0 want=1");
        end
    endtask

    task automatic run_window(input logic [7:0] bits, input logic [7:0] gaps,
                              input logic [3:0] dmask, input logic [3:0] fmask,
                              input logic [3:0] efv, input logic ew,
                              input logic ee, input int elat,
                              input int drop_after);
        bit ok;
        int wd0 = wd_cnt;
        wq.push_back('{fv: efv, w: ew, e: ee, lat: elat});
        for (int i = 0; i < 8; i++) begin
            send_bit(bits[7-i], i == 7, ok);
            if (!ok) return;
            if (i + 1 == drop_after) enable = 1'b0;
            if (i < 7 && gaps[7-i]) begin
                tick();
                tick();
            end
        end
        tick();
        tick();
        test_done = dmask;
        test_fail = fmask;
        tick();
        test_done = 4'b0;
        test_fail = 4'b0;
        wait_wd(wd0);
    endtask

    initial begin
        bit ok;
        int st0;

        // 1: reset with enable high, then IDLE -> START
        tick();
        tick();
        chk("rst_bit_ready", int'(bit_ready), 0);
        chk("rst_test_start", int'(test_start), 0);
        chk("rst_sample_valid", int'(test_sample_valid), 0);
        chk("rst_test_stop", int'(test_stop), 0);
        chk("rst_window_done", int'(window_done), 0);
        chk("rst_fail_vector", int'(fail_vector), 0);
        chk("rst_warning", int'(warning), 0);
        chk("rst_error", int'(error), 0);
        reset = 1'b0;
        chk("start_before", int'(test_start), 0);
        tick();
        chk("start_pulse", int'(test_start), 1);

        // 2: clean window with gaps
        run_window(8'b10110010, 8'b01010100, 4'b1111, 4'b0000,
                   4'b0000, 1'b0, 1'b0, 4, -1);

        // 3: two failing windows raise error, clear_error drops it
        run_window(8'b01100111, 8'b00000000, 4'b1111, 4'b0100,
                   4'b0100, 1'b1, 1'b0, -1, -1);
        run_window(8'b11001010, 8'b00100000, 4'b1111, 4'b0100,
                   4'b0100, 1'b1, 1'b1, -1, -1);
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        chk("clr_error", int'(error), 0);
        chk("clr_warning", int'(warning), 1);
        chk("clr_fail_vector", int'(fail_vector), 4);

        // 4: test 1 never reports
        run_window(8'b00011110, 8'b00000000, 4'b1101, 4'b0000,
                   4'b0010, 1'b1, 1'b0, 17, -1);

        // 5: reset after 5 accepted bits
        for (int i = 0; i < 5; i++) begin
            send_bit(i[0], 1'b0, ok);
        end
        reset = 1'b1;
        tick();
        chk("mid_rst_bit_ready", int'(bit_ready), 0);
        tick();
        chk("mid_rst_warning", int'(warning), 0);
        chk("mid_rst_fail_vector", int'(fail_vector), 0);
        reset = 1'b0;
        run_window(8'b11100001, 8'b10000001, 4'b1111, 4'b0000,
                   4'b0000, 1'b0, 1'b0, 4, -1);

        // 6: enable dropped mid-window
        run_window(8'b10011001, 8'b00000000, 4'b1111, 4'b0000,
                   4'b0000, 1'b0, 1'b0, -1, 3);
        st0 = start_cnt;
        repeat (10) tick();
        chk("idle_bit_ready", int'(bit_ready), 0);
        chk("idle_no_start", start_cnt, st0);

        chk("samples_left", sq.size(), 0);
        chk("windows_left", wq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
